icache_fill_ctrl: RTL and testbench

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

---
 rtl/icache_types.sv | 20 ++
 rtl/icache_line_buffer.sv | 32 +++
 rtl/icache_fill_ctrl.sv | 152 +++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_types.sv
// Shared types and constants for the instruction-cache fill controller.
//   - FSM state encoding (state_t and its constants)
//   - line / beat geometry: one 256-bit line is assembled from four 64-bit beats
package icache_types;

    localparam int unsigned LineWidth    = 256;
    localparam int unsigned BeatWidth    = 64;
    localparam int unsigned BeatsPerLine = 4;
    localparam int unsigned BeatIdxWidth = 2;

    typedef logic [2:0] state_t;

    localparam state_t StIdle      = 3'd0;
    localparam state_t StFetch     = 3'd1;
    localparam state_t StWrite     = 3'd2;
    localparam state_t StDone      = 3'd3;
    localparam state_t StSweep     = 3'd4;
    localparam state_t StSweepDone = 3'd5;

endpackage

// File: rtl/icache_line_buffer.sv
// Beat assembler: collects four 64-bit memory beats into one 256-bit cache line.
// Ports:
//   clk       clock
//   clear     synchronous clear of the whole line
//   wr_en     write wdata into the beat slot selected by beat_idx
//   beat_idx  beat slot (0 = least significant 64 bits)
//   wdata     beat data
//   line      assembled line (holds its value between writes)
module icache_line_buffer
    import icache_types::*;
(
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [BeatIdxWidth-1:0] beat_idx,
    input  logic [BeatWidth-1:0]    wdata,
    output logic [LineWidth-1:0]    line
);

    logic [LineWidth-1:0] line_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            line_q <= '0;
        end else if (wr_en) begin
            line_q[BeatWidth*beat_idx +: BeatWidth] <= wdata;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache fill / invalidate controller.
// A miss fetches one line as a four-beat burst from memory, then writes tag, valid
// and data for the missing set in a single cycle and pulses fill_done. An invalidate
// request clears the valid bit of every set, one set per cycle, then pulses inv_done.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   miss_req, miss_addr         fill request and missing byte address (held by requester)
//   inv_req                     invalidate-all request (held until inv_done)
//   fill_done, inv_done         one-cycle completion pulses
//   busy                        high whenever the controller is not idle
//   pmem_read, pmem_address     burst read request to memory (line-aligned address)
//   pmem_rdata, pmem_resp       one 64-bit beat per pmem_resp cycle
//   tag_load, valid_load,
//   data_load                   array write enables
//   windex, tag_out, valid_out,
//   line_out                    array write data
module icache_fill_ctrl
    import icache_types::*;
#(
    parameter int unsigned s_index  = 5,
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_tag    = 32 - s_index - s_offset
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_req,
    input  logic [31:0]          miss_addr,
    input  logic                 inv_req,
    output logic                 fill_done,
    output logic                 inv_done,
    output logic                 busy,
    output logic                 pmem_read,
    output logic [31:0]          pmem_address,
    input  logic [63:0]          pmem_rdata,
    input  logic                 pmem_resp,
    output logic                 tag_load,
    output logic                 valid_load,
    output logic                 data_load,
    output logic [s_index-1:0]   windex,
    output logic [s_tag-1:0]     tag_out,
    output logic                 valid_out,
    output logic [LineWidth-1:0] line_out
);

    localparam logic [s_index-1:0] SweepLast = '1;

    state_t                    state_q, state_d;
    logic [s_index-1:0]        index_q, index_d;
    logic [s_tag-1:0]          tag_q, tag_d;
    logic [BeatIdxWidth-1:0]   beat_q, beat_d;
    logic [s_index-1:0]        sweep_q, sweep_d;
    logic [s_index-1:0]        windex_q;
    logic [s_tag-1:0]          tag_out_q;
    logic                      beat_wr;

    // Byte-offset bits never reach the array or memory address.
    logic unused_offset;
    assign unused_offset = ^miss_addr[s_offset-1:0];

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        sweep_d = sweep_q;
        case (state_q)
            StIdle: begin
                if (inv_req) begin
                    state_d = StSweep;
                    sweep_d = '0;
                end else if (miss_req) begin
                    state_d = StFetch;
                    index_d = miss_addr[s_offset +: s_index];
                    tag_d   = miss_addr[31 -: s_tag];
                    beat_d  = '0;
                end
            end
            StFetch: begin
                if (pmem_resp) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite:     state_d = StDone;
            StDone:      state_d = StIdle;
            StSweep: begin
                // Counter wraps naturally to zero after the last set.
                sweep_d = sweep_q + s_index'(1);
                if (sweep_q == SweepLast) begin
                    state_d = StSweepDone;
                end
            end
            StSweepDone: state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q != StIdle);
        pmem_read  = (state_q == StFetch);
        fill_done  = (state_q == StDone);
        inv_done   = (state_q == StSweepDone);
        tag_load   = (state_q == StWrite);
        data_load  = (state_q == StWrite);
        valid_load = (state_q == StWrite) || (state_q == StSweep);
        valid_out  = (state_q == StWrite);
        // Array address/tag hold their last driven value when no load is active.
        windex     = windex_q;
        tag_out    = tag_out_q;
        if (state_q == StWrite) begin
            windex  = index_q;
            tag_out = tag_q;
        end else if (state_q == StSweep) begin
            windex  = sweep_q;
        end
    end

    assign pmem_address = {tag_q, index_q, {s_offset{1'b0}}};
    assign beat_wr      = (state_q == StFetch) && pmem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            index_q   <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            sweep_q   <= '0;
            windex_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            sweep_q   <= sweep_d;
            windex_q  <= windex;
            tag_out_q <= tag_out;
        end
    end

    icache_line_buffer u_line_buffer (
        .clk      (clk),
        .clear    (rst),
        .wr_en    (beat_wr),
        .beat_idx (beat_q),
        .wdata    (pmem_rdata),
        .line     (line_out)
    );

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: directed fill table, multi-cycle corner
// sequences (invalidate, priority, reset mid-burst/mid-sweep, spurious responses) and
// a randomized phase checked against an abstract set-array model.
module tb_icache_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst, miss_req, inv_req, pmem_resp;
    logic [31:0]  miss_addr;
    logic [63:0]  pmem_rdata;
    logic         fill_done, inv_done, busy, pmem_read;
    logic [31:0]  pmem_address;
    logic         tag_load, valid_load, data_load, valid_out;
    logic [4:0]   windex;
    logic [21:0]  tag_out;
    logic [255:0] line_out;

    icache_fill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .inv_req      (inv_req),
        .fill_done    (fill_done),
        .inv_done     (inv_done),
        .busy         (busy),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .tag_load     (tag_load),
        .valid_load   (valid_load),
        .data_load    (data_load),
        .windex       (windex),
        .tag_out      (tag_out),
        .valid_out    (valid_out),
        .line_out     (line_out)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;
    int n_done = 0;
    int n_write = 0;

    always @(posedge clk) begin
        if (fill_done === 1'b1) n_done  <= n_done + 1;
        if (tag_load === 1'b1)  n_write <= n_write + 1;
    end

    // The cache arrays the controller writes into.
    logic         sh_valid [32];
    logic [21:0]  sh_tag   [32];
    logic [255:0] sh_data  [32];

    always @(posedge clk) begin
        if (valid_load === 1'b1) sh_valid[windex] <= valid_out;
        if (tag_load === 1'b1)   sh_tag[windex]   <= tag_out;
        if (data_load === 1'b1)  sh_data[windex]  <= line_out;
    end

    // Abstract model of the array contents.
    bit           m_valid [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];
    logic [255:0] last_line;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] line;
        int           gap;
        logic [31:0]  exp_paddr;
        logic [4:0]   exp_idx;
        logic [21:0]  exp_tag;
    } fill_vec_t;

    fill_vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Entered with the DUT idle, sampled #1 after an edge; leaves it idle the same way.
    task automatic run_fill(input string name, input logic [31:0] addr, input logic [255:0] beats,
                            input int gap, input bit rnd, input bit drop_req,
                            input logic [31:0] exp_paddr, input logic [4:0] exp_idx,
                            input logic [21:0] exp_tag);
        int g;
        int w0;
        int d0;
        int bad_beat;
        w0 = n_write;
        d0 = n_done;
        bad_beat = -1;
        miss_req  = 1'b1;
        miss_addr = addr;
        step();
        chk({name, " pmem_read in fetch"}, pmem_read, 1'b1);
        chk({name, " pmem_address"}, pmem_address, exp_paddr);
        for (int b = 0; b < 4; b++) begin
            g = rnd ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) begin
                step();
                if (pmem_read !== 1'b1 || tag_load !== 1'b0 || pmem_address !== exp_paddr)
                    if (bad_beat < 0) bad_beat = b;
            end
            pmem_resp  = 1'b1;
            pmem_rdata = beats[64*b +: 64];
            step();
            pmem_resp  = 1'b0;
            pmem_rdata = {$urandom, $urandom};
            if (drop_req && b == 0) miss_req = 1'b0;
            if (b < 3 && (pmem_read !== 1'b1 || pmem_address !== exp_paddr))
                if (bad_beat < 0) bad_beat = b;
        end
        chk({name, " burst steady (first bad beat)"}, bad_beat, -1);
        chk({name, " write loads"}, {tag_load, valid_load, data_load, valid_out}, 4'b1111);
        chk({name, " pmem_read off in write"}, pmem_read, 1'b0);
        chk({name, " windex"}, windex, exp_idx);
        chk({name, " tag_out"}, tag_out, exp_tag);
        chk({name, " line_out"}, line_out, beats);
        chk({name, " no early fill_done"}, fill_done, 1'b0);
        step();
        miss_req = 1'b0;
        chk({name, " fill_done"}, fill_done, 1'b1);
        chk({name, " loads off in done"}, {tag_load, valid_load, data_load}, 3'b000);
        step();
        chk({name, " idle after done"}, {busy, fill_done}, 2'b00);
        chk({name, " windex held"}, windex, exp_idx);
        chk({name, " write and done count"}, (n_write - w0) * 16 + (n_done - d0), 17);
        m_valid[exp_idx] = 1'b1;
        m_tag[exp_idx]   = exp_tag;
        m_data[exp_idx]  = beats;
        last_line = beats;
    endtask

    task automatic run_sweep(input string name, input bit with_miss, input logic [31:0] addr);
        int bad;
        bad = -1;
        inv_req = 1'b1;
        if (with_miss) begin
            miss_req  = 1'b1;
            miss_addr = addr;
        end
        step();
        for (int c = 0; c < 32; c++) begin
            if (valid_load !== 1'b1 || valid_out !== 1'b0 || windex !== c[4:0] ||
                tag_load !== 1'b0 || data_load !== 1'b0 || inv_done !== 1'b0 ||
                busy !== 1'b1 || pmem_read !== 1'b0)
                if (bad < 0) bad = c;
            pmem_resp  = 1'($urandom_range(0, 1));
            pmem_rdata = {$urandom, $urandom};
            step();
        end
        pmem_resp = 1'b0;
        chk({name, " sweep sequence (first bad set)"}, bad, -1);
        chk({name, " inv_done"}, inv_done, 1'b1);
        chk({name, " loads off in sweep_done"}, {valid_load, tag_load, data_load}, 3'b000);
        chk({name, " line unchanged by sweep"}, line_out, last_line);
        inv_req = 1'b0;
        step();
        chk({name, " idle after sweep"}, {busy, inv_done}, 2'b00);
        for (int s = 0; s < 32; s++) m_valid[s] = 1'b0;
    endtask

    task automatic spurious_idle(input string name);
        for (int k = 0; k < 3; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            step();
            chk({name, " stays idle"}, {busy, pmem_read, valid_load}, 3'b000);
            chk({name, " line unchanged"}, line_out, last_line);
        end
        pmem_resp = 1'b0;
    endtask

    initial begin
        logic [31:0]  a;
        logic [255:0] l;
        int           w0;
        int           d0;
        int           op;

        vecs[0] = '{32'h0000_1234,
                    {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}},
                    0, 32'h0000_1220, 5'h11, 22'h000004};
        vecs[1] = '{32'h0000_1234,
                    {{4{16'hdddd}}, {4{16'hcccc}}, {4{16'hbbbb}}, {4{16'haaaa}}},
                    3, 32'h0000_1220, 5'h11, 22'h000004};
        vecs[2] = '{32'hffff_ffff,
                    {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0, 64'hffffffffffffffff},
                    1, 32'hffff_ffe0, 5'h1f, 22'h3fffff};
        vecs[3] = '{32'h8000_0020,
                    {64'h8, 64'h7, 64'h6, 64'h5},
                    0, 32'h8000_0020, 5'h01, 22'h200000};

        rst = 1'b1; miss_req = 1'b0; inv_req = 1'b0; pmem_resp = 1'b0;
        miss_addr = '0; pmem_rdata = '0; last_line = '0;
        step();
        step();
        chk("reset controls", {busy, fill_done, inv_done, pmem_read, tag_load, valid_load,
                               data_load, valid_out}, 8'h00);
        chk("reset pmem_address", pmem_address, 32'h0);
        chk("reset windex/tag_out", {windex, tag_out}, 27'h0);
        chk("reset line_out", line_out, 256'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++)
            run_fill($sformatf("vec%0d", i), vecs[i].addr, vecs[i].line, vecs[i].gap, 1'b0,
                     1'b0, vecs[i].exp_paddr, vecs[i].exp_idx, vecs[i].exp_tag);

        run_sweep("invalidate", 1'b0, 32'h0);
        spurious_idle("spurious idle");

        // Both requests at once: sweep first, then the held miss.
        run_sweep("priority", 1'b1, 32'h0000_2c40);
        run_fill("priority fill", 32'h0000_2c40, rand_line(), 0, 1'b0, 1'b0,
                 32'h0000_2c40, 5'h02, 22'h00000b);

        // Miss request dropped after the first beat still completes.
        run_fill("dropped req", 32'h1234_5678, rand_line(), 1, 1'b0, 1'b1,
                 32'h1234_5660, 5'h13, 22'h048d15);

        // Reset after the second beat abandons the fill.
        w0 = n_write;
        d0 = n_done;
        miss_req = 1'b1;
        miss_addr = 32'h0000_5660;
        step();
        for (int b = 0; b < 2; b++) begin
            pmem_resp = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            step();
        end
        pmem_resp = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        miss_req = 1'b0;
        last_line = '0;
        chk("rst mid-burst pmem_read/busy", {pmem_read, busy}, 2'b00);
        chk("rst mid-burst line cleared", line_out, 256'h0);
        chk("rst mid-burst pmem_address", pmem_address, 32'h0);
        for (int k = 0; k < 5; k++) step();
        chk("rst mid-burst no write/done", (n_write - w0) + (n_done - d0), 0);
        run_fill("after rst", 32'h0000_5660, rand_line(), 0, 1'b0, 1'b0,
                 32'h0000_5660, 5'h13, 22'h000015);

        // Reset mid-sweep: sets 0..9 get cleared, then no inv_done.
        inv_req = 1'b1;
        step();
        for (int k = 0; k < 9; k++) step();
        inv_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int s = 0; s <= 9; s++) m_valid[s] = 1'b0;
        last_line = '0;
        chk("rst mid-sweep idle", {busy, inv_done, valid_load}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst mid-sweep no inv_done", inv_done, 1'b0);
        end

        // Randomized operations against the set-array model.
        for (int t = 0; t < 30; t++) begin
            op = int'($urandom_range(0, 9));
            a  = $urandom;
            l  = rand_line();
            if (op < 7)
                run_fill("rand fill", a, l, 0, 1'b1, 1'($urandom_range(0, 1)),
                         a & 32'hffff_ffe0, 5'((a / 32) % 32), 22'(a / 1024));
            else if (op == 7)
                run_sweep("rand sweep", 1'b0, a);
            else if (op == 8) begin
                run_sweep("rand sweep+miss", 1'b1, a);
                run_fill("rand held fill", a, l, 0, 1'b1, 1'b0,
                         a & 32'hffff_ffe0, 5'((a / 32) % 32), 22'(a / 1024));
            end else
                spurious_idle("rand spurious");
        end

        for (int s = 0; s < 32; s++) begin
            chk($sformatf("array valid[%0d]", s), sh_valid[s], m_valid[s]);
            if (m_valid[s]) begin
                chk($sformatf("array tag[%0d]", s), sh_tag[s], m_tag[s]);
                chk($sformatf("array data[%0d]", s), sh_data[s], m_data[s]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
